// File: rtl/hamming_pkg.sv
// hamming_pkg -- shared definitions for the SECDED Hamming(16,11) decoder.
//   state_t / ST_*  : FSM state encodings used by hamming_decoder
//   flag_t / FLAG_* : per-word error flag written into the decoded high byte
//   POS_P*          : bit positions of the parity bits inside an encoded word
//   PARITY_MASK     : one-hot mask of those positions; all other bits are data
package hamming_pkg;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD_LO  = 3'd1;
    localparam state_t ST_RD_HI  = 3'd2;
    localparam state_t ST_DECODE = 3'd3;
    localparam state_t ST_WR_LO  = 3'd4;
    localparam state_t ST_WR_HI  = 3'd5;
    localparam state_t ST_FIN    = 3'd6;

    typedef logic [1:0] flag_t;
    localparam flag_t FLAG_NONE   = 2'b00;
    localparam flag_t FLAG_SINGLE = 2'b01;
    localparam flag_t FLAG_DOUBLE = 2'b10;

    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_P4 = 4;
    localparam int POS_P8 = 8;

    localparam logic [15:0] PARITY_MASK = 16'((1 << POS_P0) | (1 << POS_P1) |
                                              (1 << POS_P2) | (1 << POS_P4) |
                                              (1 << POS_P8));

endpackage

// File: rtl/hamming_decoder_secded_core.sv
// secded_core -- combinational SECDED check/correct of one encoded word.
//   W    [15:0] : encoded word {high byte, low byte}
//   data [10:0] : d11..d1 after correction (uncorrected on a double error)
//   F    [1:0]  : FLAG_NONE / FLAG_SINGLE / FLAG_DOUBLE
module secded_core
    import hamming_pkg::*;
(
    input  logic [15:0] W,
    output logic [10:0] data,
    output logic [1:0]  F
);

    logic [3:0]  syn;
    logic        par;
    logic [15:0] wc;
    logic [3:0]  j;

    always_comb begin
        syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (W[k]) syn = syn ^ 4'(k);
        end
        par = ^W;

        wc = W;
        F  = FLAG_NONE;
        if (par) begin
            // Odd overall parity: a single flip. Syndrome 0 means p0 itself
            // flipped, which carries no data, so nothing to repair.
            F = FLAG_SINGLE;
            if (syn != 4'd0) wc[syn] = ~wc[syn];
        end else if (syn != 4'd0) begin
            F = FLAG_DOUBLE;
        end

        // Data bits are every non-parity position, packed LSB first.
        data = '0;
        j    = '0;
        for (int k = 0; k < 16; k++) begin
            if (!PARITY_MASK[k]) begin
                data[j] = wc[k];
                j       = j + 4'd1;
            end
        end
    end

endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder -- reads NUM_WORDS encoded 16-bit words from byte memory,
// SECDED-decodes them and writes {flag, data} words back.
//   Clk, Reset (async, active high), Start (one-cycle request)
//   Done      : high in FIN from the cycle after FIN is reached until next Start
//   MemAddr, MemRdData (combinational read), MemWrEn, MemWrData
// Optional build macro HAMMING_DEC_STATS_EN adds CntSingle/CntDouble, the
// saturating per-run counts of corrected and uncorrectable words.
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Done,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic       MemWrEn,
    output logic [7:0] MemWrData
`ifdef HAMMING_DEC_STATS_EN
    ,
    output logic [3:0] CntSingle,
    output logic [3:0] CntDouble
`endif
);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [10:0] data_q, data_d;
    flag_t       flag_q, flag_d;
    logic        done_q, done_d;

    logic [10:0] core_data;
    flag_t       core_flag;
    logic        start_acc;
    logic        last_word;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;

    secded_core u_core (
        .W    ({hi_q, lo_q}),
        .data (core_data),
        .F    (core_flag)
    );

    assign start_acc = Start && (state_q == ST_IDLE || state_q == ST_FIN);
    assign last_word = (idx_q == 8'(NUM_WORDS - 1));
    assign src_addr  = 8'(SRC_BASE) + {idx_q[6:0], 1'b0};
    assign dst_addr  = 8'(DST_BASE) + {idx_q[6:0], 1'b0};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        data_d  = data_q;
        flag_d  = flag_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start_acc) begin
                    state_d = ST_RD_LO;
                    idx_d   = '0;
                end
            end
            ST_RD_LO: begin
                lo_d    = MemRdData;
                state_d = ST_RD_HI;
            end
            ST_RD_HI: begin
                hi_d    = MemRdData;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                data_d  = core_data;
                flag_d  = core_flag;
                state_d = ST_WR_LO;
            end
            ST_WR_LO: state_d = ST_WR_HI;
            ST_WR_HI: begin
                if (last_word) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_RD_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Done is registered off FIN, so it trails FIN entry by one cycle and
        // drops on the same edge that accepts the next Start.
        done_d = (state_q == ST_FIN) && !start_acc;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            flag_q  <= FLAG_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    // Address/data are decoded straight from the state so reset clears them
    // asynchronously along with the state register.
    always_comb begin
        MemWrEn   = 1'b0;
        MemAddr   = '0;
        MemWrData = '0;
        case (state_q)
            ST_RD_LO: MemAddr = src_addr;
            ST_RD_HI: MemAddr = src_addr + 8'd1;
            ST_WR_LO: begin
                MemWrEn   = 1'b1;
                MemAddr   = dst_addr;
                MemWrData = data_q[7:0];
            end
            ST_WR_HI: begin
                MemWrEn   = 1'b1;
                MemAddr   = dst_addr + 8'd1;
                MemWrData = {flag_q, 3'b000, data_q[10:8]};
            end
            default: ;
        endcase
    end

    assign Done = done_q;

`ifdef HAMMING_DEC_STATS_EN
    logic [3:0] cnt_single_q, cnt_single_d;
    logic [3:0] cnt_double_q, cnt_double_d;

    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (start_acc) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (state_q == ST_DECODE) begin
            if (core_flag == FLAG_SINGLE && cnt_single_q != 4'hF)
                cnt_single_d = cnt_single_q + 4'd1;
            if (core_flag == FLAG_DOUBLE && cnt_double_q != 4'hF)
                cnt_double_d = cnt_double_q + 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign CntSingle = cnt_single_q;
    assign CntDouble = cnt_double_q;
`else
    // Statistics disabled: no counter state is built.
`endif

endmodule
